// File: rtl/carregador_pkg.sv
// carregador_pkg: shared state encodings, BCD constants and a two-digit BCD increment helper.
package carregador_pkg;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_LOW, FULL, FAULT} state_t;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NOVE = 4'd9;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v[3:0] == BCD_NOVE ? {v[7:4] + 4'd1, BCD_ZERO} : {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/carregador_bandeja_if.sv
// carregador_bandeja_if: control, feeder handshake and tray level signals of the tray loader.
interface carregador_bandeja_if;

    logic       start;
    logic       clear;
    logic       feed_ack;
    logic       feed_req;
    logic [3:0] unidades_bandeja;
    logic [3:0] dezenas_bandeja;
    logic       cheia;
    logic       busy;
    logic       fault;

    modport master (
        output start, clear, feed_ack,
        input  feed_req, unidades_bandeja, dezenas_bandeja, cheia, busy, fault
    );

    modport slave (
        input  start, clear, feed_ack,
        output feed_req, unidades_bandeja, dezenas_bandeja, cheia, busy, fault
    );

endinterface

// File: rtl/bcd_digito_up.sv
// bcd_digito_up: one BCD digit counting up with enable, synchronous clear and carry out.
module bcd_digito_up
    import carregador_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       co
);

    assign co = en && q == BCD_NOVE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= BCD_ZERO;
        else if (clr)
            q <= BCD_ZERO;
        else if (en)
            q <= co ? BCD_ZERO : q + 4'd1;
    end

endmodule

// File: rtl/carregador_bandeja.sv
// carregador_bandeja: fills the tray one item per req/ack handshake until the BCD target is reached.
// Optional feeder timeout with FAULT state is enabled by defining CARREGADOR_TIMEOUT_EN.
module carregador_bandeja
    import carregador_pkg::*;
#(
    parameter logic [3:0] ALVO_UNIDADES = 4'd9,
    parameter logic [3:0] ALVO_DEZENAS  = 4'd9,
    parameter int         ACK_TIMEOUT   = 15
) (
    input logic                 clk,
    input logic                 rst,
    carregador_bandeja_if.slave bus
);

    localparam logic [7:0] ALVO = {ALVO_DEZENAS, ALVO_UNIDADES};

    state_t     state, nxt;
    logic [7:0] level;
    logic       inc, timeout, units_co, tens_co;

    assign level = {bus.dezenas_bandeja, bus.unidades_bandeja};
    // clear beats a simultaneous ack, so that ack never counts
    assign inc = state == REQ && bus.feed_ack && !bus.clear;

    bcd_digito_up u_unidades (
        .clk(clk), .rst(rst), .clr(bus.clear), .en(inc),
        .q(bus.unidades_bandeja), .co(units_co)
    );

    bcd_digito_up u_dezenas (
        .clk(clk), .rst(rst), .clr(bus.clear), .en(units_co),
        .q(bus.dezenas_bandeja), .co(tens_co)
    );

    // the level stops at the target, so the tens digit never rolls over
    always_comb assert (tens_co !== 1'b1);

`ifdef CARREGADOR_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else
            wait_cnt <= (state == REQ && !bus.clear) ? wait_cnt + 1'b1 : '0;
    end
    assign timeout = state == REQ && !bus.feed_ack && wait_cnt == CW'(ACK_TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt = state;
        if (bus.clear)
            nxt = IDLE;
        else
            case (state)
                IDLE:     if (bus.start) nxt = level == ALVO ? FULL : REQ;
                REQ:      nxt = bus.feed_ack ? WAIT_LOW : timeout ? FAULT : REQ;
                WAIT_LOW: if (!bus.feed_ack) nxt = level == ALVO ? FULL : REQ;
                default:  nxt = state;
            endcase
    end

    // outputs decode the next state so they line up with the registered level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.feed_req <= 1'b0;
            bus.busy     <= 1'b0;
            bus.fault    <= 1'b0;
            bus.cheia    <= 1'b0;
        end else begin
            state        <= nxt;
            bus.feed_req <= nxt == REQ;
            bus.busy     <= nxt == REQ || nxt == WAIT_LOW;
            bus.fault    <= nxt == FAULT;
            bus.cheia    <= bus.clear ? 1'b0 : inc ? bcd_inc(level) == ALVO : bus.cheia || nxt == FULL;
        end
    end

endmodule

// File: tb/tb_carregador_bandeja.sv
// tb_carregador_bandeja: randomized feeder against an integer tray-level model; target 12 and target 00 instances.
module tb_carregador_bandeja;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   bz_req_seen = 1'b0;

    carregador_bandeja_if bi ();
    carregador_bandeja_if bz ();

    carregador_bandeja #(.ALVO_UNIDADES(4'd2), .ALVO_DEZENAS(4'd1), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .bus(bi)
    );

    carregador_bandeja #(.ALVO_UNIDADES(4'd0), .ALVO_DEZENAS(4'd0), .ACK_TIMEOUT(4)) dut_zero (
        .clk(clk), .rst(rst), .bus(bz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bz.feed_req === 1'b1) bz_req_seen = 1'b1;

    logic [7:0]  lvl, lvl_z;
    logic [11:0] obs_m, obs_z;
    assign lvl   = {bi.dezenas_bandeja, bi.unidades_bandeja};
    assign lvl_z = {bz.dezenas_bandeja, bz.unidades_bandeja};
    assign obs_m = {bi.feed_req, lvl, bi.cheia, bi.busy, bi.fault};
    assign obs_z = {bz.feed_req, lvl_z, bz.cheia, bz.busy, bz.fault};

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic feed_one();
        int n = 0;
        while (bi.feed_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            n_cmp++; n_err++;
            $display("FAIL feed_one_wait: feed_req=%b after 20 cycles, required 1", bi.feed_req);
        end
        bi.start    = 1'b0;
        bi.feed_ack = 1'b1;
        @(negedge clk);
        bi.feed_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        bi.start = 1'b1;
        @(negedge clk);
        bi.start = 1'b0;
        n_cmp++;
        if (bi.feed_req !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_req: feed_req=%b, required 1", bi.feed_req);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_m !== 12'h000) begin
            n_err++;
            $display("FAIL reset_async_main: outputs=%h, required 000", obs_m);
        end
        n_cmp++;
        if (obs_z !== 12'h000) begin
            n_err++;
            $display("FAIL reset_async_zero: outputs=%h, required 000", obs_z);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (obs_m !== 12'h000) begin
                n_err++;
                $display("FAIL reset_idle_main: outputs=%h, required 000", obs_m);
            end
            n_cmp++;
            if (obs_z !== 12'h000) begin
                n_err++;
                $display("FAIL reset_idle_zero: outputs=%h, required 000", obs_z);
            end
        end
    endtask

    task automatic test_fill();
        int model = 0;
        int n, d, h;
        bi.start = 1'b1;
        while (model < 12) begin
            n = 0;
            while (bi.feed_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n == 20) begin
                n_cmp++; n_err++;
                $display("FAIL fill_req_wait: feed_req=%b after 20 cycles at level %0d, required 1", bi.feed_req, model);
                break;
            end
            bi.start = 1'b0;
            d = $urandom_range(0, 3);
            repeat (d) begin
                @(negedge clk);
                n_cmp++;
                if ({lvl, bi.feed_req} !== {to_bcd(model), 1'b1}) begin
                    n_err++;
                    $display("FAIL fill_req_hold: level=%h req=%b, required level=%h req=1", lvl, bi.feed_req, to_bcd(model));
                end
            end
            bi.feed_ack = 1'b1;
            h = $urandom_range(1, 2);
            model++;
            repeat (h) begin
                @(negedge clk);
                n_cmp++;
                if ({lvl, bi.feed_req, bi.cheia, bi.busy} !== {to_bcd(model), 1'b0, model == 12, 1'b1}) begin
                    n_err++;
                    $display("FAIL fill_ack: level=%h req=%b cheia=%b busy=%b, required level=%h req=0 cheia=%b busy=1",
                             lvl, bi.feed_req, bi.cheia, bi.busy, to_bcd(model), model == 12);
                end
            end
            bi.feed_ack = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({lvl, bi.feed_req, bi.cheia, bi.busy} !== {to_bcd(model), model != 12, model == 12, model != 12}) begin
                n_err++;
                $display("FAIL fill_release: level=%h req=%b cheia=%b busy=%b, required level=%h req=%b cheia=%b busy=%b",
                         lvl, bi.feed_req, bi.cheia, bi.busy, to_bcd(model), model != 12, model == 12, model != 12);
            end
        end
        bi.start = 1'b1;
        repeat (4) begin
            bi.feed_ack = ~bi.feed_ack;
            @(negedge clk);
            n_cmp++;
            if (obs_m !== {1'b0, to_bcd(12), 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL full_hold: outputs=%h, required %h", obs_m, {1'b0, to_bcd(12), 3'b100});
            end
        end
        bi.start    = 1'b0;
        bi.feed_ack = 1'b0;
    endtask

    task automatic test_clear_mid();
        bi.clear = 1'b1;
        @(negedge clk);
        bi.clear = 1'b0;
        n_cmp++;
        if (obs_m !== 12'h000) begin
            n_err++;
            $display("FAIL clear_full: outputs=%h, required 000", obs_m);
        end
        bi.feed_ack = 1'b1;
        repeat (2) @(negedge clk);
        bi.feed_ack = 1'b0;
        n_cmp++;
        if (obs_m !== 12'h000) begin
            n_err++;
            $display("FAIL ack_in_idle: outputs=%h, required 000", obs_m);
        end
        bi.start = 1'b1;
        repeat (5) feed_one();
        n_cmp++;
        if ({lvl, bi.feed_req, bi.busy} !== {to_bcd(5), 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL clear_setup: level=%h req=%b busy=%b, required level=05 req=1 busy=1", lvl, bi.feed_req, bi.busy);
        end
        bi.clear    = 1'b1;
        bi.feed_ack = 1'b1;
        @(negedge clk);
        bi.clear    = 1'b0;
        bi.feed_ack = 1'b0;
        n_cmp++;
        if (obs_m !== 12'h000) begin
            n_err++;
            $display("FAIL clear_vs_ack: outputs=%h, required 000", obs_m);
        end
        @(negedge clk);
        n_cmp++;
        if (obs_m !== 12'h000) begin
            n_err++;
            $display("FAIL clear_stays_idle: outputs=%h, required 000", obs_m);
        end
    endtask

    task automatic test_zero_target();
        bz.start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bz.cheia, bz.feed_req, bz.busy, lvl_z} !== {3'b100, 8'h00}) begin
            n_err++;
            $display("FAIL zero_full: cheia=%b req=%b busy=%b level=%h, required cheia=1 req=0 busy=0 level=00",
                     bz.cheia, bz.feed_req, bz.busy, lvl_z);
        end
        repeat (6) begin
            bz.feed_ack = ~bz.feed_ack;
            @(negedge clk);
        end
        bz.start    = 1'b0;
        bz.feed_ack = 1'b0;
        n_cmp++;
        if ({bz.cheia, bz.feed_req, lvl_z} !== {2'b10, 8'h00}) begin
            n_err++;
            $display("FAIL zero_hold: cheia=%b req=%b level=%h, required cheia=1 req=0 level=00", bz.cheia, bz.feed_req, lvl_z);
        end
        n_cmp++;
        if (bz_req_seen !== 1'b0) begin
            n_err++;
            $display("FAIL zero_no_req: feed_req seen=%b, required 0", bz_req_seen);
        end
    endtask

    task automatic test_timeout();
        int n, k;
        bi.start = 1'b1;
        feed_one();
`ifdef CARREGADOR_TIMEOUT_EN
        n = 1;
        k = 0;
        while (bi.fault !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
            if (bi.feed_req === 1'b1) n++;
        end
        n_cmp++;
        if (k == 50 || n != 4) begin
            n_err++;
            $display("FAIL timeout_cycles: fault after %0d REQ cycles (waited %0d), required 4", n, k);
        end
        n_cmp++;
        if (obs_m !== {1'b0, to_bcd(1), 3'b001}) begin
            n_err++;
            $display("FAIL timeout_state: outputs=%h, required %h", obs_m, {1'b0, to_bcd(1), 3'b001});
        end
        bi.start = 1'b1;
        repeat (3) begin
            bi.feed_ack = ~bi.feed_ack;
            @(negedge clk);
        end
        bi.start    = 1'b0;
        bi.feed_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs_m !== {1'b0, to_bcd(1), 3'b001}) begin
            n_err++;
            $display("FAIL fault_hold: outputs=%h, required %h", obs_m, {1'b0, to_bcd(1), 3'b001});
        end
`else
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (bi.feed_req === 1'b1 && bi.fault === 1'b0) n++;
        end
        n_cmp++;
        if (n != 100) begin
            n_err++;
            $display("FAIL no_timeout: req=1 fault=0 for %0d of 100 cycles, required 100", n);
        end
        k = 0;
`endif
        bi.clear = 1'b1;
        @(negedge clk);
        bi.clear = 1'b0;
        n_cmp++;
        if (obs_m !== 12'h000) begin
            n_err++;
            $display("FAIL timeout_clear: outputs=%h, required 000", obs_m);
        end
    endtask

    initial begin
        bi.start = 1'b0; bi.clear = 1'b0; bi.feed_ack = 1'b0;
        bz.start = 1'b0; bz.clear = 1'b0; bz.feed_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill();
        test_clear_mid();
        test_zero_target();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
